// File: rtl/pwm_fader_bank.sv
// Multi-channel PWM LED driver: one shared PWM counter, per-channel fade engine
// with its own prescaler and waveform mode (constant, triangle, sawtooth, one-shot).

module pwm_fader_chan #(
    parameter int N      = 8,
    parameter int RATE_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ena_i,
    input  logic              wrap_i,
    input  logic [N-1:0]      pc_i,
    input  logic              wr_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [RATE_W-1:0] cfg_rate_i,
    input  logic [N-1:0]      cfg_level_i,
    output logic              out_o,
    output logic [N-1:0]      level_o,
    output logic              done_o
);
    localparam logic [1:0] MODE_CONST    = 2'd0;
    localparam logic [1:0] MODE_TRIANGLE = 2'd1;
    localparam logic [1:0] MODE_SAWTOOTH = 2'd2;
    localparam logic [1:0] MODE_ONESHOT  = 2'd3;
    localparam logic [N-1:0] LVL_TOP_M1  = {{(N-1){1'b1}}, 1'b0};

    logic [1:0]        mode_q, mode_d;
    logic [RATE_W-1:0] rate_q, rate_d, pre_q, pre_d;
    logic [N-1:0]      level_q, level_d, duty_q, duty_d;
    logic              down_q, down_d, done_q, done_d, out_q, out_d;
    logic              tick;

    assign tick = ena_i && (rate_q != '0) && (pre_q == rate_q - 1'b1);

    always_comb begin
        mode_d  = mode_q;
        rate_d  = rate_q;
        pre_d   = pre_q;
        level_d = level_q;
        down_d  = down_q;
        done_d  = done_q;
        duty_d  = wrap_i ? level_q : duty_q;
        out_d   = (pc_i < duty_q);

        if (ena_i && rate_q != '0)
            pre_d = tick ? '0 : pre_q + 1'b1;

        if (tick) begin
            case (mode_q)
                MODE_TRIANGLE: begin
                    // Endpoints are visited once: turn around without repeating the extreme.
                    if (!down_q) begin
                        if (level_q == '1) begin
                            level_d = LVL_TOP_M1;
                            down_d  = 1'b1;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end else begin
                        if (level_q == '0) begin
                            level_d = N'(1);
                            down_d  = 1'b0;
                        end else begin
                            level_d = level_q - 1'b1;
                        end
                    end
                end
                MODE_SAWTOOTH: level_d = level_q + 1'b1;
                MODE_ONESHOT: begin
                    if (level_q != '1) level_d = level_q + 1'b1;
                    if (level_q == LVL_TOP_M1) done_d = 1'b1;
                end
                default: level_d = level_q;
            endcase
        end

        // A write overrides any tick landing on the same cycle.
        if (wr_i) begin
            mode_d  = cfg_mode_i;
            rate_d  = cfg_rate_i;
            level_d = cfg_level_i;
            pre_d   = '0;
            down_d  = 1'b0;
            done_d  = (cfg_mode_i == MODE_ONESHOT) && (cfg_level_i == '1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_CONST;
            rate_q  <= '0;
            pre_q   <= '0;
            level_q <= '0;
            duty_q  <= '0;
            down_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            pre_q   <= pre_d;
            level_q <= level_d;
            duty_q  <= duty_d;
            down_q  <= down_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign out_o   = out_q;
    assign level_o = level_q;
    assign done_o  = done_q;
endmodule

module pwm_fader_bank #(
    parameter int CHANNELS = 4,
    parameter int N        = 8,
    parameter int RATE_W   = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic                  step_i,
    input  logic                  cfg_wr_i,
    input  logic [CH_W-1:0]       cfg_ch_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [RATE_W-1:0]     cfg_rate_i,
    input  logic [N-1:0]          cfg_level_i,
    output logic [CHANNELS-1:0]   out_o,
    output logic [CHANNELS*N-1:0] levels_o,
    output logic                  period_start_o,
    output logic [CHANNELS-1:0]   done_o
);
    logic [N-1:0] pc_q, pc_d;
    logic         period_start_q;
    logic         wrap;

    assign wrap = ena_i && step_i && (pc_q == '1);

    always_comb begin
        pc_d = pc_q;
        if (ena_i && step_i) pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q           <= '0;
            period_start_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            period_start_q <= wrap;
        end
    end

    assign period_start_o = period_start_q;

    // Out-of-range channel numbers match no instance, so such writes are dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_fader_chan #(.N(N), .RATE_W(RATE_W)) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .ena_i       (ena_i),
            .wrap_i      (wrap),
            .pc_i        (pc_q),
            .wr_i        (cfg_wr_i && (cfg_ch_i == CH_W'(g))),
            .cfg_mode_i  (cfg_mode_i),
            .cfg_rate_i  (cfg_rate_i),
            .cfg_level_i (cfg_level_i),
            .out_o       (out_o[g]),
            .level_o     (levels_o[g*N +: N]),
            .done_o      (done_o[g])
        );
    end
endmodule

// File: tb/tb_pwm_fader_bank.sv
// Directed bench for pwm_fader_bank: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.

module tb_pwm_fader_bank;
    localparam int CH = 5;
    localparam int N  = 8;
    localparam int RW = 16;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst, ena, step, cfg_wr;
    logic [CW-1:0]   cfg_ch;
    logic [1:0]      cfg_mode;
    logic [RW-1:0]   cfg_rate;
    logic [N-1:0]    cfg_level;
    logic [CH-1:0]   out;
    logic [CH*N-1:0] levels;
    logic            period_start;
    logic [CH-1:0]   done;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    pwm_fader_bank #(.CHANNELS(CH), .N(N), .RATE_W(RW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ena_i          (ena),
        .step_i         (step),
        .cfg_wr_i       (cfg_wr),
        .cfg_ch_i       (cfg_ch),
        .cfg_mode_i     (cfg_mode),
        .cfg_rate_i     (cfg_rate),
        .cfg_level_i    (cfg_level),
        .out_o          (out),
        .levels_o       (levels),
        .period_start_o (period_start),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] lv(input int i);
        return levels[i*N +: N];
    endfunction

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed %0h expected <queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Issues one write; returns just after the edge that applied it.
    task automatic cfg(input logic [CW-1:0] ch, input logic [1:0] m,
                       input logic [RW-1:0] r, input logic [N-1:0] l);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_rate = r; cfg_level = l;
        step_clk();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        while (!period_start && n < 400) begin
            step_clk();
            n++;
        end
        push(64'd1);
        check("wait_period_start", 64'(period_start));
    endtask

    // 256 samples starting after a period_start cycle; optional mid-period write to ch0.
    task automatic window(input bit wr, input logic [N-1:0] nl,
                          output int hi, output int oth, output int ps);
        hi = 0; oth = 0; ps = 0;
        for (int i = 0; i < 256; i++) begin
            if (wr && i == 10) begin
                cfg_wr = 1'b1; cfg_ch = '0; cfg_mode = 2'd0; cfg_rate = '0; cfg_level = nl;
            end else begin
                cfg_wr = 1'b0;
            end
            step_clk();
            hi  += int'(out[0]);
            oth += int'(|out[CH-1:1]);
            ps  += int'(period_start);
        end
        cfg_wr = 1'b0;
    endtask

    initial begin
        int hi, oth, ps, e;
        logic ps_seen, out_chg;
        logic [CH-1:0] o0;

        rst = 1'b1; ena = 1'b1; step = 1'b1; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_rate = '0; cfg_level = '0;
        step_clk();
        step_clk();
        push(64'd0); check("reset_out", 64'(out));
        push(64'd0); check("reset_levels", 64'(levels));
        push(64'd0); check("reset_done", 64'(done));
        push(64'd0); check("reset_period_start", 64'(period_start));
        rst = 1'b0;

        // CONSTANT duty and glitch-free mid-period update
        cfg(0, 2'd0, 0, 8'd64);
        wait_ps();
        window(1'b0, 8'd0, hi, oth, ps);
        push(64'd64); check("const64_highs", 64'(hi));
        push(64'd0);  check("const64_others", 64'(oth));
        push(64'd1);  check("const64_ps_count", 64'(ps));
        window(1'b1, 8'd200, hi, oth, ps);
        push(64'd64); check("midperiod_write_highs", 64'(hi));
        window(1'b0, 8'd0, hi, oth, ps);
        push(64'd200); check("const200_highs", 64'(hi));

        // TRIANGLE turnaround at both ends
        cfg(1, 2'd1, 1, 8'd254);
        push(64'd254); check("tri_write", 64'(lv(1)));
        for (int k = 1; k <= 258; k++) begin
            step_clk();
            e = (k == 1) ? 255 : (k <= 256 ? 256 - k : k - 256);
            push(64'(e)); check("tri_seq", 64'(lv(1)));
        end

        // SAWTOOTH with prescaler 3
        cfg(2, 2'd2, 3, 8'd255);
        push(64'd255); check("saw_write", 64'(lv(2)));
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            e = (k < 3) ? 255 : k / 3 - 1;
            push(64'(e)); check("saw_seq", 64'(lv(2)));
        end

        // ONESHOT completion and rewrite
        cfg(3, 2'd3, 2, 8'd250);
        push(64'd0); check("oneshot_done_at_write", 64'(done[3]));
        for (int k = 1; k <= 14; k++) begin
            step_clk();
            e = (250 + k / 2 > 255) ? 255 : 250 + k / 2;
            push(64'(e)); check("oneshot_level", 64'(lv(3)));
            push(64'(k >= 10)); check("oneshot_done", 64'(done[3]));
        end
        cfg(3, 2'd3, 2, 8'd250);
        push(64'd0);   check("oneshot_rewrite_done", 64'(done[3]));
        push(64'd250); check("oneshot_rewrite_level", 64'(lv(3)));

        // Write landing on a tick edge wins
        cfg(2, 2'd2, 3, 8'd100);
        step_clk();
        step_clk();
        cfg(2, 2'd2, 3, 8'd50);
        push(64'd50); check("collision_level", 64'(lv(2)));
        step_clk();
        step_clk();
        push(64'd50); check("collision_hold", 64'(lv(2)));
        step_clk();
        push(64'd51); check("collision_next_tick", 64'(lv(2)));

        // Out-of-range channel writes are ignored
        cfg(1, 2'd0, 0, 8'd10);
        cfg(2, 2'd0, 0, 8'd20);
        cfg(3, 2'd0, 0, 8'd30);
        cfg(5, 2'd1, 1, 8'd7);
        cfg(7, 2'd3, 1, 8'd255);
        step_clk();
        push(64'h00_1E_14_0A_C8); check("oob_levels", 64'(levels));
        push(64'd0);              check("oob_done", 64'(done));

        // ena low freezes everything; writes still land
        ena = 1'b0;
        cfg(2, 2'd2, 1, 8'd5);
        push(64'd5); check("ena_low_write", 64'(lv(2)));
        o0 = out; ps_seen = 1'b0; out_chg = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step_clk();
            ps_seen |= period_start;
            out_chg |= (out !== o0);
        end
        push(64'h00_1E_05_0A_C8); check("ena_low_levels", 64'(levels));
        push(64'd0); check("ena_low_period_start", 64'(ps_seen));
        push(64'd0); check("ena_low_out_stable", 64'(out_chg));
        ena = 1'b1;
        step_clk();
        push(64'd6); check("ena_resume", 64'(lv(2)));

        // Reset mid-fade beats a concurrent write
        cfg(3, 2'd3, 0, 8'd255);
        push(64'd1); check("oneshot_write_top_done", 64'(done[3]));
        rst = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'd2; cfg_rate = 16'd1; cfg_level = 8'd99;
        step_clk();
        cfg_wr = 1'b0;
        push(64'd0); check("rst_out", 64'(out));
        push(64'd0); check("rst_levels", 64'(levels));
        push(64'd0); check("rst_done", 64'(done));
        push(64'd0); check("rst_period_start", 64'(period_start));
        rst = 1'b0;
        step_clk();
        step_clk();
        push(64'd0); check("rst_write_dropped", 64'(levels));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_fader_bank.md
# pwm_fader_bank

Multi-channel PWM LED driver with an independent, runtime-configurable brightness waveform per channel. It generalises the single-channel pwm + triangle_generator pairing to CHANNELS outputs sharing one PWM counter. Each channel has its own fade-rate prescaler and a waveform mode: constant, triangle, sawtooth or one-shot ramp. It sits between the top-level timing pulses and the board LED/RGB pins.

## Interface
- CHANNELS, 4, number of independent output channels (1..16)
- N, 8, PWM and level width in bits; PWM period is 2^N step pulses
- RATE_W, 16, width of the per-channel fade prescaler
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  global enable; when low, all counters, prescalers and levels hold
- step  in  1  PWM counter advance strobe (tie 1 for full-rate PWM)
- cfg_wr  in  1  single-cycle configuration write strobe
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of write
- cfg_mode  in  2  0 CONSTANT, 1 TRIANGLE, 2 SAWTOOTH, 3 ONESHOT
- cfg_rate  in  RATE_W  clk cycles per level step; 0 = level frozen
- cfg_level  in  N  starting level (CONSTANT: fixed level)
- out  out  CHANNELS  PWM outputs, registered
- levels  out  CHANNELS*N  current level per channel, channel i at [i*N +: N]
- period_start  out  1  one-cycle pulse when the PWM counter wraps to 0
- done  out  CHANNELS  ONESHOT channel has reached 2^N-1 and stopped

## Operation
- Shared PWM counter pc (N bits): pc <= pc+1 when ena && step. It wraps from 2^N-1 to 0. period_start = 1 in the cycle pc becomes 0 via wrap.
- Per-channel duty register duty[i] loads levels[i] only on the cycle pc wraps to 0. Mid-period level changes never glitch the output.
- out[i] <= (pc < duty[i]), registered each cycle. duty 0 gives constant low; duty 2^N-1 gives high for 2^N-1 of 2^N counts.
- Prescaler pre[i] (RATE_W bits) counts while ena and rate[i] != 0. At pre[i] == rate[i]-1 it clears and emits tick[i]; otherwise it increments.
- On tick[i], the mode updates levels[i]:
  - CONSTANT: no change.
  - TRIANGLE: up-direction increments. At 2^N-1 going up, the next value is 2^N-2 and direction flips to down. At 0 going down, the next value is 1 and direction flips to up. Full period is 2*(2^N-1) ticks.
  - SAWTOOTH: increments, wrapping from 2^N-1 to 0.
  - ONESHOT: increments until 2^N-1, then holds. done[i] goes to 1 in the same cycle the level reaches 2^N-1 and stays 1.
- Config write (cfg_wr && cfg_ch < CHANNELS):
  - Loads mode, rate and level.
  - Clears pre[i] and done[i], and sets direction to up.
  - If cfg_level is already 2^N-1 in ONESHOT, done[i] sets on the write cycle.
  - cfg_ch >= CHANNELS: the write is ignored.
- Config writes take effect regardless of ena.
- Arithmetic is unsigned; all level increments and decrements wrap modulo 2^N except where a mode clamps.

## Timing
- Reset values:
  - pc=0, period_start=0, out=0, done=0.
  - Every channel: level 0, duty 0, mode CONSTANT, rate 0, direction up, prescaler 0.
- Config write to visible level: levels[i] updates the cycle after cfg_wr. It reaches the output after the next pc wrap, and out reflects it one cycle later.
- tick[i] to levels[i]: 1 cycle.
- Fade step interval: rate[i] clk cycles (ena held high).
- Simultaneous cfg_wr and tick on the same channel: the write wins and the tick is discarded.
- Simultaneous cfg_wr and the duty-load wrap cycle: duty loads the old level. The new level applies from the following period.
- rst mid-operation: all state returns to reset values on the next edge, and pending writes are dropped.
- rst has priority over cfg_wr.
- ena low: pc, prescalers and levels freeze. out keeps comparing the frozen pc against duty.

## Test plan
- **Reset and CONSTANT:** rst 2 cycles, then write ch0 CONSTANT level 64, N=8, step=1 → out[0] high exactly 64 of every 256 cycles after the first period_start; other outputs stay 0.
- **TRIANGLE turnaround:** ch1 TRIANGLE rate 1 level 254 → levels[1] sequence 255, 254, 253, …, 0, 1. Check no repeat at either endpoint.
- **SAWTOOTH and prescaler:** ch2 SAWTOOTH rate 3 level 255 → levels[2] = 0 three cycles after write, then increments every 3 cycles.
- **ONESHOT completion:** ch3 ONESHOT rate 2 level 250 → done[3] rises when level hits 255 (10 cycles after write). Level holds at 255; a rewrite clears done.
- **Write/tick collision and glitch-free update:** cfg_wr on the tick cycle → level equals cfg_level. A level change mid-period leaves the current period's out unchanged.
- **Bounds, ena and reset:** write with cfg_ch=CHANNELS → no state change. ena low for 100 cycles → levels and pc constant. rst asserted mid-fade → all outputs 0 the next cycle.
